// File: rtl/mem_stage_four_pkg.sv
// Shared pipeline definitions for the MEM stage: data widths, MEM/WB control
// bundle and the FSM state encoding used by the access sequencer.
package mem_stage_four_pkg;

   localparam int WORD_W = 32;
   localparam int REG_W  = 5;

   typedef struct packed {
      logic reg_write;
      logic mem_to_reg;
   } wb_ctrl_t;

   localparam wb_ctrl_t WB_BUBBLE = '0;

   typedef enum logic {
      ST_IDLE = 1'b0,
      ST_WAIT = 1'b1
   } mem_state_e;

endpackage

// File: rtl/mem_stage_four_data_memory.sv
// Word-addressed data RAM: synchronous write, asynchronous read, no reset.
module data_memory
   import mem_stage_four_pkg::*;
#(
   parameter int ADDR_W = 8
) (
   input  logic              clk,
   input  logic              we,
   input  logic [ADDR_W-1:0] addr,
   input  logic [WORD_W-1:0] wdata,
   output logic [WORD_W-1:0] rdata
);

   logic [WORD_W-1:0] mem [2**ADDR_W];

   always_ff @(posedge clk) begin
      if (we) begin
         mem[addr] <= wdata;
      end
   end

   assign rdata = mem[addr];

endmodule

// File: rtl/mem_stage_four.sv
// MEM stage of the 5-stage MIPS core: data-memory access with optional wait
// states, branch resolution and the MEM/WB pipeline register.
module mem_stage_four
   import mem_stage_four_pkg::*;
#(
   parameter int ADDR_W      = 8,
   parameter int MEM_LATENCY = 0
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic [WORD_W-1:0] branch_target,
   input  logic [WORD_W-1:0] alu_result,
   input  logic [WORD_W-1:0] write_data,
   input  logic [REG_W-1:0]  dest_reg,
   input  logic              zero,
   input  logic              RegWrite,
   input  logic              MemToReg,
   input  logic              MemRead,
   input  logic              MemWrite,
   input  logic              Branch,
   output logic              pc_src,
   output logic [WORD_W-1:0] pc_branch,
   output logic              stall,
   output logic [WORD_W-1:0] wb_read_data,
   output logic [WORD_W-1:0] wb_alu_result,
   output logic [REG_W-1:0]  wb_dest_reg,
   output logic              wb_RegWrite,
   output logic              wb_MemToReg
);

   localparam int CNT_W = (MEM_LATENCY > 1) ? $clog2(MEM_LATENCY) : 1;
   localparam logic [CNT_W-1:0] CNT_LOAD =
      (MEM_LATENCY > 0) ? CNT_W'(MEM_LATENCY - 1) : '0;

   mem_state_e        state_q, state_d;
   logic [CNT_W-1:0]  cnt_q, cnt_d;
   logic              fsm_stall;
   logic              access;
   logic              mem_we;
   logic [WORD_W-1:0] rdata;

   logic [WORD_W-1:0] wb_read_data_q, wb_read_data_d;
   logic [WORD_W-1:0] wb_alu_result_q, wb_alu_result_d;
   logic [REG_W-1:0]  wb_dest_reg_q, wb_dest_reg_d;
   wb_ctrl_t          wb_ctrl_q, wb_ctrl_d;

   assign access    = MemRead | MemWrite;
   assign pc_src    = Branch & zero;
   assign pc_branch = branch_target;

   // Stall is gated by rst_n so it drops the moment reset asserts.
   assign stall  = fsm_stall & rst_n;
   assign mem_we = MemWrite & ~stall & rst_n;

   data_memory #(.ADDR_W(ADDR_W)) u_data_memory (
      .clk   (clk),
      .we    (mem_we),
      .addr  (alu_result[ADDR_W+1:2]),
      .wdata (write_data),
      .rdata (rdata)
   );

   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      fsm_stall = 1'b0;
      if (MEM_LATENCY > 0) begin
         case (state_q)
            ST_IDLE: begin
               if (access) begin
                  fsm_stall = 1'b1;
                  cnt_d     = CNT_LOAD;
                  state_d   = ST_WAIT;
               end
            end
            ST_WAIT: begin
               if (cnt_q != '0) begin
                  fsm_stall = 1'b1;
                  cnt_d     = cnt_q - 1'b1;
               end else begin
                  state_d = ST_IDLE;
               end
            end
            default: state_d = ST_IDLE;
         endcase
      end
   end

   // A stalled cycle pushes a bubble so write-back never sees a half-done access.
   always_comb begin
      wb_read_data_d  = '0;
      wb_alu_result_d = '0;
      wb_dest_reg_d   = '0;
      wb_ctrl_d       = WB_BUBBLE;
      if (!stall) begin
         wb_read_data_d       = rdata;
         wb_alu_result_d      = alu_result;
         wb_dest_reg_d        = dest_reg;
         wb_ctrl_d.reg_write  = RegWrite;
         wb_ctrl_d.mem_to_reg = MemToReg;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q         <= ST_IDLE;
         cnt_q           <= '0;
         wb_read_data_q  <= '0;
         wb_alu_result_q <= '0;
         wb_dest_reg_q   <= '0;
         wb_ctrl_q       <= WB_BUBBLE;
      end else begin
         state_q         <= state_d;
         cnt_q           <= cnt_d;
         wb_read_data_q  <= wb_read_data_d;
         wb_alu_result_q <= wb_alu_result_d;
         wb_dest_reg_q   <= wb_dest_reg_d;
         wb_ctrl_q       <= wb_ctrl_d;
      end
   end

   assign wb_read_data  = wb_read_data_q;
   assign wb_alu_result = wb_alu_result_q;
   assign wb_dest_reg   = wb_dest_reg_q;
   assign wb_RegWrite   = wb_ctrl_q.reg_write;
   assign wb_MemToReg   = wb_ctrl_q.mem_to_reg;

endmodule

// File: tb/tb_mem_stage_four.sv
// Directed bench for mem_stage_four: a zero-latency instance driven from a
// vector table and a three-cycle-latency instance driven by hand sequences.
module tb_mem_stage_four;

   typedef struct packed {
      logic [31:0] branch_target;
      logic [31:0] alu_result;
      logic [31:0] write_data;
      logic [4:0]  dest_reg;
      logic        zero;
      logic        reg_write;
      logic        mem_to_reg;
      logic        mem_read;
      logic        mem_write;
      logic        branch;
   } in_t;

   typedef struct {
      string       name;
      in_t         in;
      logic        exp_pc_src;
      logic        chk_rd;
      logic [31:0] exp_rd;
      logic [31:0] exp_alu;
      logic [4:0]  exp_dest;
      logic        exp_rw;
      logic        exp_m2r;
   } vec_t;

   logic clk;
   logic rst_n;
   in_t  in0, in3;

   logic        pc_src0, stall0, wb_rw0, wb_m2r0;
   logic [31:0] pc_branch0, wb_rd0, wb_alu0;
   logic [4:0]  wb_dest0;
   logic        pc_src3, stall3, wb_rw3, wb_m2r3;
   logic [31:0] pc_branch3, wb_rd3, wb_alu3;
   logic [4:0]  wb_dest3;

   int tests_run    = 0;
   int tests_failed = 0;

   localparam in_t NOP = '0;

   mem_stage_four #(.ADDR_W(8), .MEM_LATENCY(0)) u_dut0 (
      .clk(clk), .rst_n(rst_n),
      .branch_target(in0.branch_target), .alu_result(in0.alu_result),
      .write_data(in0.write_data), .dest_reg(in0.dest_reg), .zero(in0.zero),
      .RegWrite(in0.reg_write), .MemToReg(in0.mem_to_reg),
      .MemRead(in0.mem_read), .MemWrite(in0.mem_write), .Branch(in0.branch),
      .pc_src(pc_src0), .pc_branch(pc_branch0), .stall(stall0),
      .wb_read_data(wb_rd0), .wb_alu_result(wb_alu0), .wb_dest_reg(wb_dest0),
      .wb_RegWrite(wb_rw0), .wb_MemToReg(wb_m2r0)
   );

   mem_stage_four #(.ADDR_W(8), .MEM_LATENCY(3)) u_dut3 (
      .clk(clk), .rst_n(rst_n),
      .branch_target(in3.branch_target), .alu_result(in3.alu_result),
      .write_data(in3.write_data), .dest_reg(in3.dest_reg), .zero(in3.zero),
      .RegWrite(in3.reg_write), .MemToReg(in3.mem_to_reg),
      .MemRead(in3.mem_read), .MemWrite(in3.mem_write), .Branch(in3.branch),
      .pc_src(pc_src3), .pc_branch(pc_branch3), .stall(stall3),
      .wb_read_data(wb_rd3), .wb_alu_result(wb_alu3), .wb_dest_reg(wb_dest3),
      .wb_RegWrite(wb_rw3), .wb_MemToReg(wb_m2r3)
   );

   // clock / reset
   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   function automatic in_t mk(input logic [31:0] bt, input logic [31:0] alu,
                              input logic [31:0] wd, input logic [4:0] dest,
                              input logic z, input logic rw, input logic m2r,
                              input logic mr, input logic mw, input logic br);
      in_t r;
      r.branch_target = bt;  r.alu_result = alu; r.write_data = wd;
      r.dest_reg = dest;     r.zero = z;         r.reg_write = rw;
      r.mem_to_reg = m2r;    r.mem_read = mr;    r.mem_write = mw;
      r.branch = br;
      return r;
   endfunction

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      tests_run++;
      if (act !== exp) begin
         tests_failed++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
      end
   endtask

   task automatic next_cycle();
      @(posedge clk);
      #1;
   endtask

   // Drive one access on the latency-3 instance and wait for completion.
   task automatic run3(input string name, input in_t v);
      int n;
      n = 0;
      in3 = v;
      #1;
      while (stall3 && n < 20) begin
         next_cycle();
         #1;
         n++;
      end
      check({name, "_stall_cycles"}, n, 3);
      next_cycle();
      in3 = NOP;
   endtask

   vec_t vecs[11];
   in_t  rtype;

   initial begin
      rtype = mk(32'h0, 32'h1234_5678, 32'h0, 5'd17, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);

      vecs[0]  = '{"st_10", mk(0, 32'h10, 32'hDEAD_BEEF, 5'd0, 0, 0, 0, 0, 1, 0),
                   1'b0, 1'b0, 32'h0, 32'h10, 5'd0, 1'b0, 1'b0};
      vecs[1]  = '{"ld_13", mk(0, 32'h13, 32'h0, 5'd8, 0, 1, 1, 1, 0, 0),
                   1'b0, 1'b1, 32'hDEAD_BEEF, 32'h13, 5'd8, 1'b1, 1'b1};
      vecs[2]  = '{"br_taken", mk(32'h40, 32'h0, 32'h0, 5'd0, 1, 0, 0, 0, 0, 1),
                   1'b1, 1'b0, 32'h0, 32'h0, 5'd0, 1'b0, 1'b0};
      vecs[3]  = '{"br_not_taken", mk(32'h40, 32'h0, 32'h0, 5'd0, 0, 0, 0, 0, 0, 1),
                   1'b0, 1'b0, 32'h0, 32'h0, 5'd0, 1'b0, 1'b0};
      vecs[4]  = '{"st_0_5", mk(0, 32'h0, 32'h5, 5'd0, 0, 0, 0, 0, 1, 0),
                   1'b0, 1'b0, 32'h0, 32'h0, 5'd0, 1'b0, 1'b0};
      vecs[5]  = '{"rw_0_9", mk(0, 32'h0, 32'h9, 5'd3, 0, 1, 1, 1, 1, 0),
                   1'b0, 1'b1, 32'h5, 32'h0, 5'd3, 1'b1, 1'b1};
      vecs[6]  = '{"ld_0_9", mk(0, 32'h0, 32'h0, 5'd4, 0, 1, 1, 1, 0, 0),
                   1'b0, 1'b1, 32'h9, 32'h0, 5'd4, 1'b1, 1'b1};
      vecs[7]  = '{"st_400", mk(0, 32'h400, 32'hCAFE_F00D, 5'd0, 0, 0, 0, 0, 1, 0),
                   1'b0, 1'b0, 32'h0, 32'h400, 5'd0, 1'b0, 1'b0};
      vecs[8]  = '{"ld_wrap_0", mk(0, 32'h0, 32'h0, 5'd5, 0, 1, 1, 1, 0, 0),
                   1'b0, 1'b1, 32'hCAFE_F00D, 32'h0, 5'd5, 1'b1, 1'b1};
      vecs[9]  = '{"rtype", rtype,
                   1'b0, 1'b0, 32'h0, 32'h1234_5678, 5'd17, 1'b1, 1'b0};
      vecs[10] = '{"ld_hi_bits", mk(0, 32'hFFFF_FC10, 32'h0, 5'd31, 0, 1, 1, 1, 0, 0),
                   1'b0, 1'b1, 32'hDEAD_BEEF, 32'hFFFF_FC10, 5'd31, 1'b1, 1'b1};

      // Reset held with arbitrary (memory) traffic on both instances.
      rst_n = 1'b0;
      in0 = mk(32'h44, 32'h20, 32'h77, 5'd9, 1, 1, 1, 1, 1, 1);
      in3 = in0;
      repeat (3) next_cycle();
      check("rst_stall0", stall0, 0);
      check("rst_stall3", stall3, 0);
      check("rst_wb_alu0", wb_alu0, 0);
      check("rst_wb_rd0", wb_rd0, 0);
      check("rst_wb_rw3", wb_rw3, 0);
      check("rst_wb_dest3", wb_dest3, 0);

      in0 = rtype;
      in3 = NOP;
      rst_n = 1'b1;
      next_cycle();
      check("post_rst_alu0", wb_alu0, 32'h1234_5678);
      check("post_rst_dest0", wb_dest0, 17);
      check("post_rst_rw0", wb_rw0, 1);

      // Table on the zero-latency instance.
      for (int i = 0; i < 11; i++) begin
         in0 = vecs[i].in;
         #1;
         check({vecs[i].name, "_pc_src"}, pc_src0, vecs[i].exp_pc_src);
         check({vecs[i].name, "_pc_branch"}, pc_branch0, vecs[i].in.branch_target);
         check({vecs[i].name, "_stall"}, stall0, 0);
         next_cycle();
         if (vecs[i].chk_rd) check({vecs[i].name, "_wb_rd"}, wb_rd0, vecs[i].exp_rd);
         check({vecs[i].name, "_wb_alu"}, wb_alu0, vecs[i].exp_alu);
         check({vecs[i].name, "_wb_dest"}, wb_dest0, vecs[i].exp_dest);
         check({vecs[i].name, "_wb_rw"}, wb_rw0, vecs[i].exp_rw);
         check({vecs[i].name, "_wb_m2r"}, wb_m2r0, vecs[i].exp_m2r);
      end
      in0 = rtype;

      // Latency-3 load of 0x1234 from 0x20 with bubble checks.
      run3("l3_st20", mk(0, 32'h20, 32'h1234, 5'd0, 0, 0, 0, 0, 1, 0));
      in3 = mk(0, 32'h20, 32'h0, 5'd9, 0, 1, 1, 1, 0, 0);
      for (int c = 1; c <= 3; c++) begin
         #1;
         check($sformatf("l3_ld_stall_c%0d", c), stall3, 1);
         next_cycle();
         check($sformatf("l3_ld_bubble_rw_c%0d", c), wb_rw3, 0);
         check($sformatf("l3_ld_bubble_rd_c%0d", c), wb_rd3, 0);
      end
      #1;
      check("l3_ld_stall_c4", stall3, 0);
      check("l3_ld_pc_src", pc_src3, 0);
      next_cycle();
      check("l3_ld_rd", wb_rd3, 32'h1234);
      check("l3_ld_dest", wb_dest3, 9);
      check("l3_ld_rw", wb_rw3, 1);
      in3 = NOP;
      next_cycle();

      // Branch on the stalled instance is still combinational.
      in3 = mk(32'h80, 32'h8, 32'h0, 5'd0, 1, 0, 0, 1, 0, 1);
      #1;
      check("l3_br_during_stall", pc_src3, 1);
      check("l3_br_stall", stall3, 1);
      run3("l3_br_ld", mk(32'h80, 32'h8, 32'h0, 5'd0, 1, 0, 0, 1, 0, 1));

      // Reset during the second stall cycle of a store drops the store.
      run3("l3_st8_init", mk(0, 32'h8, 32'h1, 5'd0, 0, 0, 0, 0, 1, 0));
      in3 = mk(0, 32'h8, 32'hAAAA, 5'd0, 0, 0, 0, 0, 1, 0);
      #1;
      check("l3_abort_stall_c1", stall3, 1);
      next_cycle();
      check("l3_abort_stall_c2", stall3, 1);
      rst_n = 1'b0;
      #1;
      check("l3_abort_stall_drop", stall3, 0);
      check("mid_rst_wb_alu0", wb_alu0, 0);
      check("mid_rst_wb_rw0", wb_rw0, 0);
      repeat (2) next_cycle();
      check("l3_abort_stall_hold", stall3, 0);
      in3 = rtype;
      rst_n = 1'b1;
      #1;
      check("l3_rtype_no_stall", stall3, 0);
      next_cycle();
      check("l3_rtype_alu", wb_alu3, 32'h1234_5678);
      check("l3_rtype_rw", wb_rw3, 1);
      in3 = NOP;
      run3("l3_ld8", mk(0, 32'h8, 32'h0, 5'd4, 0, 1, 1, 1, 0, 0));
      check("l3_ld8_rd_unchanged", wb_rd3, 32'h1);

      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule

// File: doc/mem_stage_four.md
Name: mem_stage_four

Overview:
- Fourth pipeline stage (MEM) of the 5-stage MIPS core.
- Consumes the EX/MEM register outputs of the execute stage.
- Performs the data-memory access against an internal word-addressed RAM and resolves the branch decision for the fetch stage.
- Registers results into the MEM/WB pipeline register feeding write-back.
- Supports a parameterised memory latency, with a stall handshake back to the upstream stages.

Parameters:
- ADDR_W, 8, word-index width; RAM holds 2^ADDR_W 32-bit words.
- MEM_LATENCY, 0, extra wait cycles per load/store (0 = single-cycle access).

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous active-low reset.
- branch_target  input  32  EX/MEM branch target address.
- alu_result  input  32  EX/MEM ALU result; doubles as memory byte address.
- write_data  input  32  EX/MEM store data (rt value).
- dest_reg  input  5  EX/MEM destination register.
- zero  input  1  EX/MEM ALU zero flag.
- RegWrite, MemToReg, MemRead, MemWrite, Branch  input  1 each  EX/MEM control bits.
- pc_src  output  1  branch taken to fetch (combinational).
- pc_branch  output  32  equals branch_target (combinational pass-through).
- stall  output  1  upstream must hold the EX/MEM register and freeze PC/IF/ID while high.
- wb_read_data  output  32  MEM/WB load data.
- wb_alu_result  output  32  MEM/WB ALU result.
- wb_dest_reg  output  5  MEM/WB destination register.
- wb_RegWrite, wb_MemToReg  output  1 each  MEM/WB control bits.

Behaviour:
- Reset (async, rst_n=0):
  - All wb_* outputs clear to 0.
  - FSM goes to IDLE and the wait counter clears to 0.
  - stall is 0.
  - RAM contents are not reset.
- Addressing:
  - Word index = alu_result[ADDR_W+1:2].
  - alu_result[1:0] is ignored.
  - Upper address bits are ignored, so accesses wrap modulo RAM size.
- Access detection: an access is requested when MemRead|MemWrite is high. When both are high, the access is a store, and wb_read_data captures the pre-write word.
- Branch resolution:
  - pc_src = Branch & zero, purely combinational.
  - pc_src is independent of stall; branches never access memory.
- MEM_LATENCY=0:
  - No stall.
  - A store writes the RAM at the clock edge.
  - A load's asynchronous RAM read is registered into wb_read_data at the same edge.
  - MEM/WB latency is 1 cycle.
- MEM_LATENCY=N>0, FSM states IDLE and WAIT:
  - IDLE with an access requested: stall=1 combinationally; counter loads N-1 and the FSM moves to WAIT. A counter load of 0 means a single WAIT cycle.
  - WAIT with counter>0: stall=1 and the counter decrements.
  - WAIT with counter==0: stall=0. The store commits or the load is captured at this edge, and the FSM returns to IDLE.
  - Total occupancy per access is N+1 cycles: stall is high for N cycles, and the access completes on cycle N+1.
  - On return to IDLE, the next instruction is presented. If it is also an access, it restarts the sequence from IDLE; there is no back-to-back bypass.
- Bubble insertion: while stall=1, MEM/WB loads a bubble (all wb_* = 0, so wb_RegWrite=0).
- Non-memory instructions always pass through in 1 cycle with no stall.
- RAM write enable = MemWrite & ~stall, so exactly one write occurs per store.
- Upstream contract: the EX/MEM inputs must remain stable while stall=1. The block does not re-latch them.
- Reset during WAIT aborts the access. The pending store is dropped with the RAM unchanged, and stall falls immediately.

Decomposition:
- Shared pipeline package holds:
  - word width constant (32);
  - register-index width (5);
  - MEM/WB control field bundle and its bubble constant (all zero).
- One sub-module, data_memory: 2^ADDR_W x 32 RAM with synchronous write and asynchronous read.
- The FSM, counter and MEM/WB register live in mem_stage_four.

Test Plan:
1. Reset:
   - Stimulus: hold rst_n=0 mid-run with arbitrary inputs.
   - Response: all wb_* are 0 and stall=0; after release, the first non-memory instruction appears on wb_* one cycle later.
2. Store then load, LATENCY=0:
   - Stimulus: MemWrite, alu_result=0x10, write_data=0xDEADBEEF; next cycle MemRead, MemToReg, RegWrite, dest_reg=8, alu_result=0x13.
   - Response: wb_read_data=0xDEADBEEF, wb_dest_reg=8, wb_RegWrite=1, no stall.
3. Branch:
   - Stimulus: Branch=1, zero=1, branch_target=0x40.
   - Response: pc_src=1 and pc_branch=0x40 in the same cycle.
   - Stimulus: zero=0.
   - Response: pc_src=0.
4. LATENCY=3 load:
   - Stimulus: MemRead at 0x20, which holds 0x1234.
   - Response: stall is high for exactly 3 cycles with bubbles on wb_* (wb_RegWrite=0); on cycle 4 stall=0 and wb_read_data=0x1234 at the following edge.
5. Simultaneous read and write:
   - Stimulus: MemRead=MemWrite=1 at 0x0, old value 0x5, write_data=0x9.
   - Response: wb_read_data=0x5; a subsequent load from 0x0 returns 0x9.
6. Reset mid-WAIT:
   - Stimulus: LATENCY=3; assert rst_n=0 during the 2nd stall cycle of a store of 0xAAAA to 0x8, which previously held 0x1.
   - Response: stall drops immediately and a later load from 0x8 returns 0x1.
7. Wrap-around (ADDR_W=8):
   - Stimulus: store to 0x400.
   - Response: a load from 0x0 returns the stored value.
